// File: rtl/decoder_pkg.sv
// Shared constants and operation decode for the decoder stack and its controller.
package decoder_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } stack_op_e;

  // Push and pop in the same cycle is a swap of the top entry.
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/decoder_stack_mem.sv
// Stack storage: STACK_DEPTH x DATA_WIDTH register file, one synchronous write
// port and one combinational read port. No reset on the array.
module decoder_stack_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(STACK_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [$clog2(STACK_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]          rdata
);

  logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decoder_stack.sv
// LIFO stack with registered pop data, same-cycle push/pop swap and empty bypass.
// Define DECODER_STACK_ERR_EN to add sticky overflow/underflow outputs.
module decoder_stack
  import decoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count
`ifdef DECODER_STACK_ERR_EN
  ,
  output logic                             overflow,
  output logic                             underflow
`endif
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = $clog2(STACK_DEPTH);

  logic [CW-1:0]         sp, sp_d, sp_m1;
  logic [DATA_WIDTH-1:0] dout_d, rdata;
  logic                  dv_d;
  logic                  we;
  logic [AW-1:0]         waddr, top_addr;
  stack_op_e             op;

  assign op       = decode_op(push, pop);
  assign sp_m1    = sp - CW'(1);
  assign top_addr = AW'(sp_m1);
  assign empty    = (sp == '0);
  assign full     = (sp == CW'(STACK_DEPTH));
  assign count    = sp;

  decoder_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(top_addr),
    .rdata(rdata)
  );

  // Next-state decode; clear overrides any push/pop and blocks the write.
  always_comb begin
    sp_d   = sp;
    dout_d = dout;
    dv_d   = 1'b0;
    we     = 1'b0;
    waddr  = AW'(sp);
    if (clear) begin
      sp_d = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (!full) begin
            we   = 1'b1;
            sp_d = sp + CW'(1);
          end
        end
        OP_POP: begin
          if (!empty) begin
            dout_d = rdata;
            dv_d   = 1'b1;
            sp_d   = sp_m1;
          end
        end
        OP_SWAP: begin
          dv_d = 1'b1;
          if (empty) begin
            dout_d = din;
          end else begin
            dout_d = rdata;
            we     = 1'b1;
            waddr  = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      sp         <= sp_d;
      dout       <= dout_d;
      dout_valid <= dv_d;
    end
  end

`ifdef DECODER_STACK_ERR_EN
  // Sticky flags for rejected push (full) and rejected pop (empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (op == OP_PUSH && full)  overflow  <= 1'b1;
      if (op == OP_POP  && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_stack.sv
// Scoreboard bench for decoder_stack: queue-based reference stack, directed
// scenarios followed by randomized push/pop/clear traffic.
module tb_decoder_stack;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, clear, push, pop;
  logic [DW-1:0] din, dout;
  logic          dout_valid, empty, full;
  logic [CW-1:0] count;
`ifdef DECODER_STACK_ERR_EN
  logic          overflow, underflow;
`endif

  decoder_stack #(
    .DATA_WIDTH (DW),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .dout      (dout),
    .dout_valid(dout_valid),
    .empty     (empty),
    .full      (full),
    .count     (count)
`ifdef DECODER_STACK_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the stack as a queue (top = last element).
  logic [DW-1:0] stk[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_dv   = 1'b0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state against the model and drains the scoreboard.
  always @(negedge clk) begin
    chk("dout_valid", DW'(dout_valid), DW'(m_dv));
    chk("dout_hold", dout, m_dout);
    chk("count", DW'(count), DW'(stk.size()));
    chk("empty", DW'(empty), DW'(stk.size() == 0));
    chk("full", DW'(full), DW'(stk.size() == DEPTH));
`ifdef DECODER_STACK_ERR_EN
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("underflow", DW'(underflow), DW'(m_unf));
`endif
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: unexpected dout %0h at %0t", dout, $time);
      end else begin
        chk("scoreboard", dout, exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of stimulus and advance the model to the post-edge state.
  task automatic op(input logic c, input logic ps, input logic pp, input logic [DW-1:0] d);
    logic [DW-1:0] out;
    @(negedge clk);
    #1;
    clear = c;
    push  = ps;
    pop   = pp;
    din   = d;
    m_dv  = 1'b0;
    if (c) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (ps && pp) begin
      if (stk.size() == 0) begin
        out = d;
      end else begin
        out = stk[stk.size() - 1];
        stk[stk.size() - 1] = d;
      end
      m_dv   = 1'b1;
      m_dout = out;
      exp_q.push_back(out);
    end else if (ps) begin
      if (stk.size() < DEPTH) stk.push_back(d);
      else m_ovf = 1'b1;
    end else if (pp) begin
      if (stk.size() > 0) begin
        out    = stk.pop_back();
        m_dv   = 1'b1;
        m_dout = out;
        exp_q.push_back(out);
      end else begin
        m_unf = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    stk.delete();
    exp_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  logic    r_clr, r_push, r_pop;
  bit      heavy_push;

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    #1;
    chk("reset_dout", dout, '0);
    chk("reset_dv", DW'(dout_valid), '0);
    chk("reset_count", DW'(count), '0);
    chk("reset_empty", DW'(empty), DW'(1));
    chk("reset_full", DW'(full), '0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // LIFO order with one-cycle pop latency
    op(0, 1, 0, 32'h11);
    op(0, 1, 0, 32'h22);
    op(0, 1, 0, 32'h33);
    op(0, 0, 1, '0);
    op(0, 0, 1, '0);
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);

    // Fill to full, rejected push, pop returns last accepted word
    for (int i = 1; i <= int'(DEPTH); i++) op(0, 1, 0, DW'(32'h100 + i));
    op(0, 1, 0, 32'hDEAD);
    op(0, 0, 0, '0);
    op(0, 0, 1, '0);
    op(0, 1, 1, 32'h5A5A);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);

    // Pop on empty, then swap bypass on empty
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);
    op(0, 1, 1, 32'hAB);
    op(0, 0, 0, '0);
    op(1, 0, 0, '0);

    // Swap with occupied stack
    op(0, 1, 0, 32'h01);
    op(0, 1, 0, 32'h02);
    op(0, 1, 1, 32'h99);
    op(0, 0, 1, '0);
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);

    // Clear wins over a simultaneous push
    for (int i = 0; i < 5; i++) op(0, 1, 0, DW'(32'hC0 + i));
    op(1, 1, 0, 32'hEE);
    op(0, 0, 0, '0);

    // Asynchronous reset while a pop result is being presented
    op(0, 1, 0, 32'h71);
    op(0, 1, 0, 32'h72);
    op(0, 0, 1, '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dv", DW'(dout_valid), '0);
    chk("async_rst_dout", dout, '0);
    chk("async_rst_count", DW'(count), '0);
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    op(0, 1, 0, 32'h81);
    op(0, 0, 1, '0);
    op(0, 0, 0, '0);

    // Randomized traffic alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 800; i++) begin
      heavy_push = ((i / 100) % 2) == 0;
      r_clr  = ($urandom_range(99) < 2);
      r_push = ($urandom_range(99) < (heavy_push ? 70 : 35));
      r_pop  = ($urandom_range(99) < (heavy_push ? 30 : 65));
      op(r_clr, r_push, r_pop, $urandom);
    end

    repeat (3) op(0, 0, 0, '0);
    @(negedge clk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
